// File: rtl/accel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_ctrl_pkg
// Description : Shared constants for the accelerator control front-end:
//               state encoding, control-block register offsets, STATUS bit
//               positions and the unmapped-read value.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_ctrl_pkg;

    // Controller states, 3-bit encoding visible through CTRL readback
    localparam logic [2:0] RST = 3'd0;
    localparam logic [2:0] CFG = 3'd1;
    localparam logic [2:0] RUN = 3'd2;
    localparam logic [2:0] FIN = 3'd3;
    localparam logic [2:0] ERR = 3'd4;

    // Control-block register offsets, relative to CTRL_OFS
    localparam logic [31:0] OFS_CTRL   = 32'h0;
    localparam logic [31:0] OFS_STATUS = 32'h4;
    localparam logic [31:0] OFS_IRQ_EN = 32'h8;
    localparam logic [31:0] OFS_CYCLES = 32'hC;

    // STATUS layout: [1:0] state low bits, then done, tmo, irq
    localparam int STS_DONE_BIT = 2;
    localparam int STS_TMO_BIT  = 3;
    localparam int STS_IRQ_BIT  = 4;

    // Returned for in-range addresses that map to no register
    localparam logic [31:0] RDATA_UNMAPPED = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/accel_ctrl_shadow_rf.sv
`default_nettype none
// ============================================================================
// Module      : accel_ctrl_shadow_rf
// Description : NUM_CFG x 32 shadow register bank. Byte-strobe write,
//               combinational read, and the strobe-merged value of the
//               addressed entry (what the entry becomes after the write).
// Revision    : 1.0 - initial release
// ============================================================================
module accel_ctrl_shadow_rf #(
    parameter int NUM_CFG = 19,
    parameter int SEL_W   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_idx,
    input  logic [3:0]       i_wr_strb,
    input  logic [31:0]      i_wr_data,
    output logic [31:0]      o_rd_data,
    output logic [31:0]      o_merged
);

    logic [31:0] shadow_q [NUM_CFG];
    logic [31:0] shadow_d [NUM_CFG];

    // Select the addressed entry and merge the write data into it per byte
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (i_idx == SEL_W'(i)) begin
                o_rd_data = shadow_q[i];
            end
        end
        for (int b = 0; b < 4; b++) begin
            o_merged[8*b +: 8] = i_wr_strb[b] ? i_wr_data[8*b +: 8] : o_rd_data[8*b +: 8];
        end
    end

    // Next value of every entry: only the addressed one changes on a write
    always_comb begin
        for (int i = 0; i < NUM_CFG; i++) begin
            shadow_d[i] = (i_wr_en && (i_idx == SEL_W'(i))) ? o_merged : shadow_q[i];
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_reg
        // Shadow storage, cleared by reset
        always_ff @(posedge clk) begin
            if (!resetn) begin
                shadow_q[g] <= '0;
            end else begin
                shadow_q[g] <= shadow_d[g];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/accel_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accel_cfg_ctrl
// Description : Memory-mapped control/configuration front-end on the PicoRV32
//               native bus: shadowed config registers with a one-cycle write
//               pulse, run-state machine, sticky done/timeout status, run-cycle
//               counter, watchdog and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_cfg_ctrl
    import accel_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_1000,
    parameter int          NUM_CFG   = 19,
    parameter logic [31:0] CTRL_OFS  = 32'h80,
    parameter logic [31:0] TIMEOUT   = 32'd0,
    parameter int          SEL_W     = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_wdata,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic             cal_fin,
    output logic [SEL_W-1:0] cfgreg_sel,
    output logic [31:0]      cfgreg_wdata,
    output logic             cfgreg_wenb,
    output logic             flow_enb,
    output logic             flow_resetn,
    output logic             irq
);

    logic [2:0]       state_q, state_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic             en_q, en_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             mem_ready_q, mem_ready_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic             cfgreg_wenb_q, cfgreg_wenb_d;
    logic [SEL_W-1:0] cfgreg_sel_q, cfgreg_sel_d;
    logic [31:0]      cfgreg_wdata_q, cfgreg_wdata_d;
    logic             flow_enb_q, flow_enb_d;
    logic             flow_resetn_q, flow_resetn_d;
    logic             irq_q, irq_d;

    logic [31:0]      ofs_w, wofs_w, rd_val_w, status_w, shadow_rd_w, merged_w;
    logic             hit_w, accept_w, is_wr_w, cfg_sel_w, cfg_wr_w;
    logic             ctrl_wr_w, sts_wr_w, irqen_wr_w, done_set_w, tmo_set_w;
    logic [SEL_W-1:0] cfg_idx_w;

    // Address decode: the window covers the config bank and the 4-word control block
    assign ofs_w     = mem_addr - BASE_ADDR;
    assign wofs_w    = {ofs_w[31:2], 2'b00};
    assign hit_w     = mem_valid && (mem_addr >= BASE_ADDR) && (ofs_w < CTRL_OFS + 32'd16);
    assign accept_w  = hit_w && !mem_ready_q;
    assign is_wr_w   = |mem_wstrb;
    assign cfg_sel_w = ofs_w < 32'(NUM_CFG * 4);
    assign cfg_idx_w = ofs_w[SEL_W+1:2];

    // Config writes only land in CFG; elsewhere they are acknowledged and dropped
    assign cfg_wr_w   = accept_w && is_wr_w && cfg_sel_w && (state_q == CFG);
    assign ctrl_wr_w  = accept_w && mem_wstrb[0] && (wofs_w == CTRL_OFS + OFS_CTRL);
    assign sts_wr_w   = accept_w && mem_wstrb[0] && (wofs_w == CTRL_OFS + OFS_STATUS);
    assign irqen_wr_w = accept_w && mem_wstrb[0] && (wofs_w == CTRL_OFS + OFS_IRQ_EN);

    accel_ctrl_shadow_rf #(
        .NUM_CFG (NUM_CFG),
        .SEL_W   (SEL_W)
    ) u_shadow (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (cfg_wr_w),
        .i_idx     (cfg_idx_w),
        .i_wr_strb (mem_wstrb),
        .i_wr_data (mem_wdata),
        .o_rd_data (shadow_rd_w),
        .o_merged  (merged_w)
    );

    // Read multiplexer over the shadow bank and the control block
    always_comb begin
        status_w               = '0;
        status_w[1:0]          = state_q[1:0];
        status_w[STS_DONE_BIT] = done_q;
        status_w[STS_TMO_BIT]  = tmo_q;
        status_w[STS_IRQ_BIT]  = irq_q;
        rd_val_w               = RDATA_UNMAPPED;
        if (cfg_sel_w) begin
            rd_val_w = shadow_rd_w;
        end else if (wofs_w == CTRL_OFS + OFS_CTRL) begin
            rd_val_w = {29'd0, state_q};
        end else if (wofs_w == CTRL_OFS + OFS_STATUS) begin
            rd_val_w = status_w;
        end else if (wofs_w == CTRL_OFS + OFS_IRQ_EN) begin
            rd_val_w = {31'd0, en_q};
        end else if (wofs_w == CTRL_OFS + OFS_CYCLES) begin
            rd_val_w = cycles_q;
        end
    end

    // Next-state logic: run events first, then W1C, then CTRL writes which override all
    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        done_set_w = 1'b0;
        tmo_set_w  = 1'b0;
        if (state_q == RUN) begin
            if (cycles_q != 32'hFFFF_FFFF) begin
                cycles_d = cycles_q + 32'd1;
            end
            if (cal_fin) begin
                state_d    = FIN;
                done_set_w = 1'b1;
            end else if ((TIMEOUT != 32'd0) && (cycles_q == TIMEOUT - 32'd1)) begin
                state_d   = ERR;
                tmo_set_w = 1'b1;
            end
        end
        // A set event on the same edge beats the W1C clear
        done_d = done_set_w || (done_q && !(sts_wr_w && mem_wdata[STS_DONE_BIT]));
        tmo_d  = tmo_set_w  || (tmo_q  && !(sts_wr_w && mem_wdata[STS_TMO_BIT]));
        en_d   = irqen_wr_w ? mem_wdata[0] : en_q;
        if (ctrl_wr_w) begin
            case (mem_wdata[1:0])
                2'd0: begin
                    state_d  = RST;
                    done_d   = 1'b0;
                    tmo_d    = 1'b0;
                    cycles_d = '0;
                end
                2'd1: if (state_q == RST) state_d = CFG;
                2'd2: if ((state_q == RST) || (state_q == CFG)) state_d = RUN;
                default: ;
            endcase
        end
        if ((state_q != RUN) && (state_d == RUN)) begin
            cycles_d = '0;
        end
        irq_d          = en_d && (done_d || tmo_d);
        flow_enb_d     = (state_d == RUN);
        flow_resetn_d  = (state_d != RST);
        mem_ready_d    = accept_w;
        mem_rdata_d    = (accept_w && !is_wr_w) ? rd_val_w : '0;
        cfgreg_wenb_d  = cfg_wr_w;
        cfgreg_sel_d   = cfg_wr_w ? cfg_idx_w : SEL_W'(NUM_CFG);
        cfgreg_wdata_d = cfg_wr_w ? merged_w : '0;
    end

    // Controller registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= RST;
            done_q         <= 1'b0;
            tmo_q          <= 1'b0;
            en_q           <= 1'b0;
            cycles_q       <= '0;
            mem_ready_q    <= 1'b0;
            mem_rdata_q    <= '0;
            cfgreg_wenb_q  <= 1'b0;
            cfgreg_sel_q   <= SEL_W'(NUM_CFG);
            cfgreg_wdata_q <= '0;
            flow_enb_q     <= 1'b0;
            flow_resetn_q  <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            tmo_q          <= tmo_d;
            en_q           <= en_d;
            cycles_q       <= cycles_d;
            mem_ready_q    <= mem_ready_d;
            mem_rdata_q    <= mem_rdata_d;
            cfgreg_wenb_q  <= cfgreg_wenb_d;
            cfgreg_sel_q   <= cfgreg_sel_d;
            cfgreg_wdata_q <= cfgreg_wdata_d;
            flow_enb_q     <= flow_enb_d;
            flow_resetn_q  <= flow_resetn_d;
            irq_q          <= irq_d;
        end
    end

    assign mem_ready    = mem_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign cfgreg_wenb  = cfgreg_wenb_q;
    assign cfgreg_sel   = cfgreg_sel_q;
    assign cfgreg_wdata = cfgreg_wdata_q;
    assign flow_enb     = flow_enb_q;
    assign flow_resetn  = flow_resetn_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_cfg_ctrl
// Description : Directed self-checking bench for accel_cfg_ctrl (TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_cfg_ctrl;

    localparam logic [31:0] BASE = 32'h0200_1000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        cal_fin;
    logic [4:0]  cfgreg_sel;
    logic [31:0] cfgreg_wdata;
    logic        cfgreg_wenb;
    logic        flow_enb;
    logic        flow_resetn;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        cap_wenb;
    logic [4:0]  cap_sel;
    logic [31:0] cap_wdata;
    logic [31:0] rdat;
    int          lat;
    int          run_cnt;

    always #5 clk = ~clk;

    accel_cfg_ctrl #(
        .BASE_ADDR (BASE),
        .NUM_CFG   (19),
        .CTRL_OFS  (32'h80),
        .TIMEOUT   (32'd16),
        .SEL_W     (5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .cal_fin      (cal_fin),
        .cfgreg_sel   (cfgreg_sel),
        .cfgreg_wdata (cfgreg_wdata),
        .cfgreg_wenb  (cfgreg_wenb),
        .flow_enb     (flow_enb),
        .flow_resetn  (flow_resetn),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transfer; returns data and latency in cycles (0 = never acknowledged)
    task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic fin, output logic [31:0] rd, output int l);
        rd       = '0;
        l        = 0;
        cap_wenb = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = d;
        cal_fin   = fin;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                l         = k;
                rd        = mem_rdata;
                cap_wenb  = cfgreg_wenb;
                cap_sel   = cfgreg_sel;
                cap_wdata = cfgreg_wdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        cal_fin   = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        xfer(a, s, d, 1'b0, rdat, lat);
        chk({tag, "_ack"}, 32'(lat), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        xfer(a, 4'h0, 32'h0, 1'b0, rdat, lat);
        chk({tag, "_ack"}, 32'(lat), 32'd1);
        chk(tag, rdat, exp);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0; cal_fin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_wenb", 32'(cfgreg_wenb), 32'd0);
        chk("rst_sel", 32'(cfgreg_sel), 32'd19);
        chk("rst_wdata", cfgreg_wdata, 32'd0);
        chk("rst_flow_enb", 32'(flow_enb), 32'd0);
        chk("rst_flow_resetn", 32'(flow_resetn), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;

        // Config write while in RST is acknowledged but dropped
        wr("cfg_in_rst", BASE, 4'hF, 32'h1234_5678);
        chk("cfg_in_rst_wenb", 32'(cap_wenb), 32'd0);
        rd_chk("cfg_in_rst_rb", BASE, 32'h0);

        // Enter CFG, strobed config write with pulse
        wr("ctrl_cfg", BASE + 32'h80, 4'h1, 32'h1);
        chk("cfg_flow_resetn", 32'(flow_resetn), 32'd1);
        chk("cfg_flow_enb", 32'(flow_enb), 32'd0);
        rd_chk("ctrl_rb_cfg", BASE + 32'h80, 32'd1);
        wr("cfg_w8", BASE + 32'h8, 4'b0011, 32'hDEAD_BEEF);
        chk("cfg_w8_wenb", 32'(cap_wenb), 32'd1);
        chk("cfg_w8_sel", 32'(cap_sel), 32'd2);
        chk("cfg_w8_wdata", cap_wdata, 32'h0000_BEEF);
        @(posedge clk); #1;
        chk("cfg_w8_ready_drop", 32'(mem_ready), 32'd0);
        chk("cfg_w8_wenb_drop", 32'(cfgreg_wenb), 32'd0);
        chk("cfg_w8_sel_idle", 32'(cfgreg_sel), 32'd19);
        rd_chk("cfg_w8_rb", BASE + 32'h8, 32'h0000_BEEF);
        wr("cfg_w8_hi", BASE + 32'h8, 4'b1100, 32'h1234_5678);
        chk("cfg_w8_hi_wdata", cap_wdata, 32'h1234_BEEF);
        rd_chk("cfg_w8_hi_rb", BASE + 32'h8, 32'h1234_BEEF);

        // Decode boundaries
        rd_chk("unmapped_cfg_end", BASE + 32'h4C, 32'hFFFF_FFFF);
        rd_chk("unmapped_gap", BASE + 32'h7C, 32'hFFFF_FFFF);
        xfer(BASE - 32'h4, 4'h0, 32'h0, 1'b0, rdat, lat);
        chk("miss_below_ack", 32'(lat), 32'd0);
        xfer(BASE + 32'h90, 4'h0, 32'h0, 1'b0, rdat, lat);
        chk("miss_above_ack", 32'(lat), 32'd0);

        // Normal run: 10 RUN cycles then cal_fin
        wr("irq_en", BASE + 32'h88, 4'h1, 32'h1);
        rd_chk("irq_en_rb", BASE + 32'h88, 32'h1);
        wr("ctrl_run", BASE + 32'h80, 4'h1, 32'h2);
        chk("run_flow_enb", 32'(flow_enb), 32'd1);
        run_cnt = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (flow_enb) run_cnt++;
        end
        chk("run_flow_cnt", 32'(run_cnt), 32'd9);
        cal_fin = 1'b1;
        @(posedge clk); #1;
        cal_fin = 1'b0;
        chk("fin_flow_enb", 32'(flow_enb), 32'd0);
        chk("fin_irq", 32'(irq), 32'd1);
        rd_chk("fin_status", BASE + 32'h84, 32'h17);
        rd_chk("fin_cycles", BASE + 32'h8C, 32'd10);
        wr("w1c_done", BASE + 32'h84, 4'h1, 32'h4);
        chk("w1c_irq", 32'(irq), 32'd0);
        rd_chk("w1c_status", BASE + 32'h84, 32'h3);
        wr("ctrl_rst", BASE + 32'h80, 4'h1, 32'h0);
        chk("ctrl_rst_flow_resetn", 32'(flow_resetn), 32'd0);
        rd_chk("ctrl_rst_cycles", BASE + 32'h8C, 32'd0);

        // Watchdog: no cal_fin, ERR after 16 RUN cycles
        wr("wd_run", BASE + 32'h80, 4'h1, 32'h2);
        repeat (15) @(posedge clk);
        #1;
        chk("wd_pre_flow_enb", 32'(flow_enb), 32'd1);
        @(posedge clk); #1;
        chk("wd_flow_enb", 32'(flow_enb), 32'd0);
        chk("wd_irq", 32'(irq), 32'd1);
        rd_chk("wd_ctrl", BASE + 32'h80, 32'd4);
        rd_chk("wd_status", BASE + 32'h84, 32'h18);
        rd_chk("wd_cycles", BASE + 32'h8C, 32'd16);
        wr("wd_ignore_run", BASE + 32'h80, 4'h1, 32'h2);
        rd_chk("wd_ctrl_still_err", BASE + 32'h80, 32'd4);
        wr("wd_clr", BASE + 32'h80, 4'h1, 32'h0);

        // cal_fin on the would-be timeout edge wins
        wr("corner_run", BASE + 32'h80, 4'h1, 32'h2);
        repeat (15) @(posedge clk);
        #1;
        cal_fin = 1'b1;
        @(posedge clk); #1;
        cal_fin = 1'b0;
        rd_chk("corner_ctrl", BASE + 32'h80, 32'd3);
        rd_chk("corner_status", BASE + 32'h84, 32'h17);
        wr("corner_clr", BASE + 32'h80, 4'h1, 32'h0);

        // CTRL=0 on the same edge as cal_fin
        wr("race_run", BASE + 32'h80, 4'h1, 32'h2);
        xfer(BASE + 32'h80, 4'h1, 32'h0, 1'b1, rdat, lat);
        chk("race_ack", 32'(lat), 32'd1);
        chk("race_flow_resetn", 32'(flow_resetn), 32'd0);
        rd_chk("race_ctrl", BASE + 32'h80, 32'd0);
        rd_chk("race_status", BASE + 32'h84, 32'h0);

        // Reset asserted on an acceptance edge
        wr("mid_cfg", BASE + 32'h80, 4'h1, 32'h1);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = BASE + 32'h80; mem_wstrb = 4'h0; resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid_ready", 32'(mem_ready), 32'd0);
        chk("mid_rdata", mem_rdata, 32'd0);
        chk("mid_flow_resetn", 32'(flow_resetn), 32'd0);
        chk("mid_sel", 32'(cfgreg_sel), 32'd19);
        chk("mid_irq", 32'(irq), 32'd0);
        mem_valid = 1'b0;
        resetn = 1'b1;
        rd_chk("mid_irq_en", BASE + 32'h88, 32'h0);
        rd_chk("mid_shadow", BASE + 32'h8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
